regbank_arbiter: RTL

Shared 8-bit register bank with two host ports: port 0 serves the SPI peripheral, port 1 the I2C peripheral. Each port connects directly to a peripheral's application bus (addr, wdata, single-cycle we, rdata). Writes are buffered one-deep per port and committed through a round-robin write arbiter. Sticky error and collision status is readable and clearable at a reserved address.

---
 rtl/regbank_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/regbank_arbiter.sv
// ---------------------------------------------------------------------------
// regbank_arbiter
//
// Shared 8-bit register bank with two host ports (port 0 = SPI peripheral,
// port 1 = I2C peripheral). Each port has a one-deep write buffer. A
// round-robin arbiter commits at most one buffered write per cycle. Sticky
// overflow, address-error and collision status is readable at STATUS_ADDR,
// and writing there clears bits (write-one-to-clear).
//
// Handshake: pX_we is a single-cycle strobe with no ready/back-pressure.
// A strobe is captured when the port buffer is empty or is being drained
// in the same cycle. Otherwise it is dropped and the port overflow bit is
// set. Reads have no handshake: pX_rdata is registered every cycle from
// pX_addr and reflects committed state only.
//
// Configuration macro: ARB_FIXED_PRIORITY_EN
//   defined     -> ties always granted to port 0
//   not defined -> ties alternate (round-robin on last grant)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ena                   1 = accept new write captures
//   p0_we/p1_we           single-cycle write strobes
//   p0_addr/p1_addr [7:0] register address (write target and read address)
//   p0_wdata/p1_wdata     write data
//   p0_rdata/p1_rdata     registered read data
//   regs_o                flat bank contents, reg k at [8k+7:8k]
//   status_o              {coll_cnt[2:0], coll, p1_aerr, p0_aerr, p1_ovf, p0_ovf}
// ---------------------------------------------------------------------------
module regbank_arbiter #(
   parameter int         NUM_REGS    = 16,
   parameter logic [7:0] STATUS_ADDR = 8'hFF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic                  p0_we,
   input  logic                  p1_we,
   input  logic [7:0]            p0_addr,
   input  logic [7:0]            p1_addr,
   input  logic [7:0]            p0_wdata,
   input  logic [7:0]            p1_wdata,
   output logic [7:0]            p0_rdata,
   output logic [7:0]            p1_rdata,
   output logic [8*NUM_REGS-1:0] regs_o,
   output logic [7:0]            status_o
);

   localparam int         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

   logic [7:0]       r_regs [NUM_REGS];
   logic [7:0]       r_status;
   logic [1:0]       r_pend;
   logic [7:0]       r_addr [2];
   logic [7:0]       r_data [2];
   logic [7:0]       r_p0_rdata;
   logic [7:0]       r_p1_rdata;
`ifndef ARB_FIXED_PRIORITY_EN
   logic             r_last_grant;
`endif

   logic [1:0]       w_we;
   logic [7:0]       w_in_addr [2];
   logic [7:0]       w_in_data [2];
   logic [1:0]       w_gnt;
   logic [1:0]       w_cap;
   logic [1:0]       w_ovf;
   logic             w_coll;
   logic             w_commit;
   logic             w_sel;
   logic [7:0]       w_c_addr;
   logic [7:0]       w_c_data;
   logic             w_c_is_reg;
   logic             w_c_is_stat;
   logic [IDX_W-1:0] w_c_idx;
   logic [7:0]       w_status_nxt;

   assign w_we         = {p1_we, p0_we};
   assign w_in_addr[0] = p0_addr;
   assign w_in_addr[1] = p1_addr;
   assign w_in_data[0] = p0_wdata;
   assign w_in_data[1] = p1_wdata;

   // Arbitration on the pending bits only.
   always_comb begin
      w_gnt = 2'b00;
`ifdef ARB_FIXED_PRIORITY_EN
      if (r_pend[0])      w_gnt = 2'b01;
      else if (r_pend[1]) w_gnt = 2'b10;
`else
      // On a tie, the port that did not win last time is served.
      if (r_pend == 2'b11) w_gnt = r_last_grant ? 2'b01 : 2'b10;
      else                 w_gnt = r_pend;
`endif
   end

   assign w_coll      = &r_pend;
   assign w_commit    = |w_gnt;
   assign w_sel       = w_gnt[1];
   assign w_c_addr    = r_addr[w_sel];
   assign w_c_data    = r_data[w_sel];
   assign w_c_is_reg  = ({1'b0, w_c_addr} < NUM_REGS_W);
   assign w_c_is_stat = (w_c_addr == STATUS_ADDR);
   assign w_c_idx     = w_c_addr[IDX_W-1:0];

   // A buffer being drained this cycle can refill from a same-cycle strobe.
   assign w_cap = w_we & {2{ena}} & (~r_pend | w_gnt);
   assign w_ovf = w_we & {2{ena}} & r_pend & ~w_gnt;

   always_comb begin
      w_status_nxt      = r_status;
      w_status_nxt[1:0] = r_status[1:0] | w_ovf;
      if (w_commit && !w_c_is_reg && !w_c_is_stat) begin
         if (w_sel) w_status_nxt[3] = 1'b1;
         else       w_status_nxt[2] = 1'b1;
      end
      if (w_coll) begin
         w_status_nxt[4] = 1'b1;
         if (r_status[7:5] != 3'd7) w_status_nxt[7:5] = r_status[7:5] + 3'd1;
      end
      // Clear is applied last so it wins over same-cycle set events.
      if (w_commit && w_c_is_stat) w_status_nxt = w_status_nxt & ~w_c_data;
   end

   function automatic logic [7:0] read_mux(input logic [7:0] a);
      logic [7:0] v;
      v = 8'h00;
      if ({1'b0, a} < NUM_REGS_W) v = r_regs[a[IDX_W-1:0]];
      else if (a == STATUS_ADDR)  v = r_status;
      return v;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend     <= 2'b00;
         r_addr[0]  <= 8'h00;
         r_addr[1]  <= 8'h00;
         r_data[0]  <= 8'h00;
         r_data[1]  <= 8'h00;
         r_status   <= 8'h00;
         r_p0_rdata <= 8'h00;
         r_p1_rdata <= 8'h00;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (w_cap[i]) begin
               r_pend[i] <= 1'b1;
               r_addr[i] <= w_in_addr[i];
               r_data[i] <= w_in_data[i];
            end else if (w_gnt[i]) begin
               r_pend[i] <= 1'b0;
            end
         end
         r_status   <= w_status_nxt;
         r_p0_rdata <= read_mux(p0_addr);
         r_p1_rdata <= read_mux(p1_addr);
      end
   end

`ifndef ARB_FIXED_PRIORITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_last_grant <= 1'b1;
      else if (w_commit) r_last_grant <= w_sel;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= 8'h00;
      end else if (w_commit && w_c_is_reg) begin
         r_regs[w_c_idx] <= w_c_data;
      end
   end

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
      assign regs_o[8*k +: 8] = r_regs[k];
   end

   assign p0_rdata = r_p0_rdata;
   assign p1_rdata = r_p1_rdata;
   assign status_o = r_status;

endmodule
